// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: op and state enums,
// RV32 width codes and writeback exception codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'b01,
        STORE = 2'b10
    } lsu_op_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to the RV32 load width code.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        data    = rdata;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'h000000, shifted[7:0]};
            F3_HU:   data = {16'h0000, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: decodes an execute-stage request, issues
// one word-aligned memory access and returns a one-cycle writeback pulse.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [1:0]  ex_op,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_exc
);

    lsu_state_e  state_q, state_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [4:0]  rd_q, rd_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [1:0]  wb_exc_q, wb_exc_d;

    logic        is_load, is_store, illegal, misaligned;
    logic [3:0]  store_strb;
    logic [31:0] store_data, load_data;

    // Request decode; illegal always wins over misaligned when both apply.
    always_comb begin
        is_load    = (ex_op == LOAD);
        is_store   = (ex_op == STORE);
        illegal    = !(is_load || is_store) || (ex_funct3 == 3'b011) ||
                     (ex_funct3[2:1] == 2'b11) || (is_store && ex_funct3[2]);
        misaligned = ((ex_funct3 == F3_H || ex_funct3 == F3_HU) && ex_addr[0]) ||
                     ((ex_funct3 == F3_W) && (ex_addr[1:0] != 2'b00));
        store_strb = 4'b1111;
        store_data = ex_wdata;
        case (ex_funct3[1:0])
            2'b00: begin
                store_strb = 4'b0001 << ex_addr[1:0];
                store_data = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                store_strb = 4'b0011 << {ex_addr[1], 1'b0};
                store_data = {2{ex_wdata[15:0]}};
            end
            default: begin
                store_strb = 4'b1111;
                store_data = ex_wdata;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (addr_lo_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        rd_d        = rd_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_exc_d    = wb_exc_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (illegal || misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ex_addr;
                        wb_exc_d   = illegal ? EXC_ILLEGAL : EXC_MISALIGN;
                    end else begin
                        state_d     = BUSY;
                        is_load_d   = is_load;
                        funct3_d    = ex_funct3;
                        addr_lo_d   = ex_addr[1:0];
                        rd_d        = ex_rd;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {ex_addr[31:2], 2'b00};
                        mem_wdata_d = store_data;
                        mem_wstrb_d = is_store ? store_strb : 4'b0000;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_we_d     = is_load_q;
                    wb_rd_d     = rd_q;
                    wb_data_d   = is_load_q ? load_data : 32'h0;
                    wb_exc_d    = EXC_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset mid-transaction drops the memory request and any pending writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            rd_q        <= 5'd0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'h0;
            wb_exc_q    <= EXC_NONE;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            rd_q        <= rd_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_exc_q    <= wb_exc_d;
        end
    end

    assign ex_ready  = (state_q == IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign wb_exc    = wb_exc_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a driver pushes expected memory requests and
// writebacks from a reference model; a memory responder and a monitor check them.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  ex_op;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc;

    typedef struct {
        logic [1:0]  exc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          chkRd;
        int          cyc;
    } wbExp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          isStore;
        int          waits;
        logic [31:0] rdata;
    } memExp_t;

    wbExp_t  wbQ[$];
    memExp_t memQ[$];
    int      compared = 0;
    int      mismatched = 0;
    int      cyc = 0;

    lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_funct3 (ex_funct3),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_rd     (ex_rd),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_exc    (wb_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request and push what the reference model says must happen.
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd, input int waits,
                                 input logic [31:0] rdata, input int gap);
        int      n;
        int      acc;
        int      size;
        int      off;
        bit      illegal;
        bit      mis;
        wbExp_t  w;
        memExp_t m;
        logic [31:0] v;
        for (int g = 0; g < gap; g++) begin
            ex_valid = 1'b0;
            @(negedge clk);
        end
        ex_valid  = 1'b1;
        ex_op     = op;
        ex_funct3 = f3;
        ex_addr   = addr;
        ex_wdata  = wdata;
        ex_rd     = rd;
        n = 0;
        while (!ex_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ex_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: got ex_ready=0, expected 1 within 100 cycles");
            ex_valid = 1'b0;
            return;
        end
        acc  = cyc + 1;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = int'(addr[1:0]);
        illegal = (op != 2'd1 && op != 2'd2) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 ||
                  (op == 2'd2 && f3[2]);
        mis = !illegal && ((addr % size) != 0);
        w.rd    = rd;
        w.chkRd = 1'b0;
        if (illegal || mis) begin
            w.exc  = illegal ? 2'b10 : 2'b01;
            w.we   = 1'b0;
            w.data = addr;
            w.cyc  = acc;
        end else begin
            m.addr    = addr & 32'hFFFF_FFFC;
            m.isStore = (op == 2'd2);
            m.waits   = waits;
            m.rdata   = rdata;
            m.wstrb   = 4'b0000;
            m.wdata   = 32'h0;
            for (int i = 0; i < 4; i++) begin
                m.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
                if (m.isStore && i >= off && i < off + size) m.wstrb[i] = 1'b1;
            end
            memQ.push_back(m);
            w.exc = 2'b00;
            w.cyc = acc + 1 + waits;
            if (m.isStore) begin
                w.we   = 1'b0;
                w.data = 32'h0;
            end else begin
                v = rdata >> (8 * off);
                if (size == 1) begin
                    v = v & 32'h0000_00FF;
                    if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
                end else if (size == 2) begin
                    v = v & 32'h0000_FFFF;
                    if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
                end
                w.we    = 1'b1;
                w.data  = v;
                w.chkRd = 1'b1;
            end
        end
        wbQ.push_back(w);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    // Memory responder: checks each request, inserts wait states, drives noise otherwise.
    initial begin : responder
        memExp_t cur;
        bit      active;
        int      remaining;
        logic [31:0] sAddr, sWdata;
        logic [3:0]  sStrb;
        active = 1'b0;
        remaining = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
                mem_ready = 1'b0;
            end else if (mem_valid) begin
                checkOutput("ex_ready_while_busy", {31'h0, ex_ready}, 32'h0);
                if (!active) begin
                    if (memQ.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_mem_valid: got mem_addr 0x%08h, expected no request", mem_addr);
                        cur.waits = 0;
                        cur.rdata = 32'h0;
                    end else begin
                        cur = memQ.pop_front();
                        checkOutput("mem_addr", mem_addr, cur.addr);
                        checkOutput("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, cur.wstrb});
                        if (cur.isStore) checkOutput("mem_wdata", mem_wdata, cur.wdata);
                    end
                    sAddr = mem_addr;
                    sWdata = mem_wdata;
                    sStrb = mem_wstrb;
                    remaining = cur.waits;
                    active = 1'b1;
                end else begin
                    checkOutput("mem_addr_stable", mem_addr, sAddr);
                    checkOutput("mem_wdata_stable", mem_wdata, sWdata);
                    checkOutput("mem_wstrb_stable", {28'h0, mem_wstrb}, {28'h0, sStrb});
                end
                if (remaining == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = cur.rdata;
                    active = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    remaining--;
                end
            end else begin
                if (active) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL mem_valid_dropped: got mem_valid 0, expected 1 until mem_ready");
                    active = 1'b0;
                end
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    // Writeback monitor: every pulse must match the oldest expectation, on the expected cycle.
    initial begin : monitor
        wbExp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wb_valid) begin
                if (wbQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_wb_valid: got wb_data 0x%08h, expected no writeback", wb_data);
                end else begin
                    e = wbQ.pop_front();
                    checkOutput("wb_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("wb_exc", {30'h0, wb_exc}, {30'h0, e.exc});
                    checkOutput("wb_we", {31'h0, wb_we}, {31'h0, e.we});
                    checkOutput("wb_data", wb_data, e.data);
                    if (e.chkRd) checkOutput("wb_rd", {27'h0, wb_rd}, {27'h0, e.rd});
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((wbQ.size() != 0 || memQ.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (wbQ.size() != 0 || memQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d writebacks and %0d memory requests outstanding, expected 0",
                     wbQ.size(), memQ.size());
            wbQ.delete();
            memQ.delete();
        end
    endtask

    initial begin : driver
        logic [2:0] legalF3[5];
        logic [1:0] op;
        logic [2:0] f3;
        logic [31:0] addr;
        int r;
        int size;
        legalF3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0;
        ex_valid = 1'b0;
        ex_op = 2'b00;
        ex_funct3 = 3'b000;
        ex_addr = 32'h0;
        ex_wdata = 32'h0;
        ex_rd = 5'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ex_ready", {31'h0, ex_ready}, 32'h1);
        checkOutput("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        checkOutput("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        checkOutput("rst_wb_we", {31'h0, wb_we}, 32'h0);
        checkOutput("rst_wb_rd", {27'h0, wb_rd}, 32'h0);
        checkOutput("rst_wb_data", wb_data, 32'h0);
        checkOutput("rst_wb_exc", {30'h0, wb_exc}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ex_ready", {31'h0, ex_ready}, 32'h1);

        applyStimulus(2'b01, 3'b010, 32'h0000_1000, 32'h0, 5'd1, 0, 32'hDEAD_BEEF, 0);
        applyStimulus(2'b01, 3'b000, 32'h0000_1003, 32'h0, 5'd2, 0, 32'h80FF_FFFF, 1);
        applyStimulus(2'b01, 3'b100, 32'h0000_1003, 32'h0, 5'd3, 0, 32'h80FF_FFFF, 1);
        applyStimulus(2'b10, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd4, 0, 32'h0, 1);
        applyStimulus(2'b01, 3'b010, 32'h0000_4000, 32'h0, 5'd5, 3, 32'h1357_9BDF, 1);
        applyStimulus(2'b01, 3'b010, 32'h0000_3001, 32'h0, 5'd6, 0, 32'h0, 1);
        applyStimulus(2'b11, 3'b010, 32'h0000_3001, 32'h0, 5'd7, 0, 32'h0, 0);
        applyStimulus(2'b10, 3'b100, 32'h0000_5000, 32'h0, 5'd8, 0, 32'h0, 0);
        applyStimulus(2'b01, 3'b101, 32'h0000_6002, 32'h0, 5'd9, 1, 32'h8001_7FFF, 0);
        drain();

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 19);
            op = (r < 9) ? 2'b01 : (r < 18) ? 2'b10 : (r == 18) ? 2'b00 : 2'b11;
            if ($urandom_range(0, 9) < 9) f3 = legalF3[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 7));
            size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr = addr & ~32'(size - 1);
            applyStimulus(op, f3, addr, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom,
                          $urandom_range(0, 2));
        end
        drain();

        applyStimulus(2'b01, 3'b010, 32'h0000_7000, 32'h0, 5'd10, 10, 32'hCAFE_F00D, 0);
        checkOutput("pre_rst_mem_valid", {31'h0, mem_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        wbQ.delete();
        memQ.delete();
        #1;
        checkOutput("async_rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        checkOutput("async_rst_ex_ready", {31'h0, ex_ready}, 32'h1);
        checkOutput("async_rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("after_rst_ex_ready", {31'h0, ex_ready}, 32'h1);
        checkOutput("after_rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        applyStimulus(2'b01, 3'b001, 32'h0000_8002, 32'h0, 5'd11, 0, 32'h8765_4321, 0);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
Parameters: none; all datapaths fixed at 32 bits.
REQ-001 The block SHALL have one clock and asynchronous active-low reset, with these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  request from execute stage
- ex_ready  out  1  LSU can accept a request
- ex_op  in  2  01 load, 10 store, 00/11 illegal
- ex_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr  in  32  effective byte address
- ex_wdata  in  32  store data, LSB-aligned
- ex_rd  in  5  load destination register
- mem_valid  out  1  memory request, master side
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables; 0000 = read
- mem_ready  in  1  memory accepts the request; rdata valid this cycle
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle completion pulse
- wb_we  out  1  register write enable (successful load)
- wb_rd  out  5  destination register
- wb_data  out  32  load result, or faulting address on exception
- wb_exc  out  2  00 none, 01 misaligned, 10 illegal

Function
REQ-002 The LSU SHALL have two states: IDLE and BUSY.
REQ-003 ex_ready SHALL be 1 only in IDLE.
REQ-004 A request SHALL be accepted on a clock edge where ex_valid=1 and ex_ready=1; op, funct3, addr, wdata and rd SHALL be registered at that edge.
REQ-005 The following SHALL be illegal: ex_op of 00 or 11; funct3 of 011, 110 or 111; a store with funct3[2]=1.
REQ-006 A request SHALL be misaligned when it is H/HU with addr[0]=1, or W with addr[1:0]!=00.
REQ-007 An illegal or misaligned request SHALL NOT enter BUSY and SHALL NOT assert mem_valid.
REQ-008 For such a request, wb_valid SHALL be 1 in the cycle after acceptance, with wb_exc 10 (illegal takes priority over misaligned) or 01, wb_we=0 and wb_data=addr.
REQ-009 A legal request SHALL move to BUSY, and mem_valid SHALL be 1 from the cycle after acceptance.
REQ-010 mem_valid, mem_addr, mem_wdata and mem_wstrb SHALL be registered and SHALL stay stable until the edge where mem_ready=1.
REQ-011 mem_addr SHALL be {addr[31:2],2'b00}.
REQ-012 Store strobes SHALL be: SB 0001<<addr[1:0]; SH 0011<<{addr[1],1'b0}; SW 1111. Loads SHALL use 0000.
REQ-013 mem_wdata SHALL be {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-014 At the edge where BUSY and mem_ready=1, the LSU SHALL return to IDLE and register the writeback, so wb_valid=1 in the next cycle, together with ex_ready=1.
REQ-015 Load data SHALL be selected by addr[1:0]: B/H sign-extended, BU/HU zero-extended, W unmodified.
REQ-016 A load completion SHALL set wb_we=1 and wb_rd=rd.
REQ-017 A store completion SHALL set wb_we=0 and wb_data=0.
REQ-018 wb_valid SHALL be exactly one cycle wide.
REQ-019 A new request MAY be accepted in the same cycle wb_valid is high.
REQ-020 mem_ready SHALL be ignored in IDLE.
REQ-021 mem_rdata SHALL be sampled only at the BUSY edge where mem_ready=1.
REQ-022 Minimum latency SHALL be 2 cycles from acceptance to wb_valid with zero-wait memory; each memory wait cycle SHALL add one cycle.

Reset
REQ-023 While rst_n=0, all outputs SHALL be 0 except ex_ready, and the state SHALL be IDLE.
REQ-024 ex_ready SHALL be 1 after reset release.
REQ-025 Reset asserted during BUSY SHALL drop mem_valid asynchronously and discard the pending writeback; no wb_valid SHALL follow.

Structure
REQ-026 The shared package SHALL hold: the lsu_op_e enum (LOAD, STORE), funct3 width localparams, the wb_exc codes, and the IDLE/BUSY state enum.
REQ-027 The load alignment and extension logic SHALL be one combinational sub-module, lsu_load_align, with inputs rdata, addr[1:0] and funct3, and output data.

Verification
REQ-028 LW at 0x1000 with mem_rdata=0xDEADBEEF and zero wait -> mem_addr=0x1000, mem_wstrb=0000; wb_valid 2 cycles after acceptance with wb_data=0xDEADBEEF and wb_we=1.
REQ-029 LB at 0x1003 with rdata=0x80FFFFFF -> wb_data=0xFFFFFF80. LBU with the same inputs -> wb_data=0x00000080.
REQ-030 SH at 0x2002 with wdata=0x1234ABCD -> mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_addr=0x2000; wb_we=0.
REQ-031 mem_ready held 0 for 3 cycles -> mem_* signals stable throughout; ex_ready=0; wb_valid 5 cycles after acceptance.
REQ-032 LW at 0x3001 -> no mem_valid; wb_exc=01, wb_data=0x3001. ex_op=11 -> wb_exc=10.
REQ-033 rst_n pulsed low in BUSY -> mem_valid=0 immediately; no wb_valid; ex_ready=1 after release.
